// File: rtl/uart64_pkg.sv
// uart64_pkg: shared constants and FSM state types for the 64-bit UART word link.
package uart64_pkg;
    localparam int BYTES_PER_WORD = 8;
    localparam int BITS_PER_FRAME = 10;
    localparam int DATA_BITS = BITS_PER_FRAME - 2;
    localparam int TIMEOUT_BITS = 20;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 2-flop synchronised 8N1 receiver; re-checks the start bit at half a
// bit and samples data and stop bits mid-bit, flagging a good byte or a framing error.
module uart_byte_rx
    import uart64_pkg::*;
#(
    parameter int CLK_GOAL = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       rx_idle
);
    localparam int CW = $clog2(CLK_GOAL + 1);
    localparam logic [CW-1:0] FULL = CW'(CLK_GOAL - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_GOAL / 2 - 1);

    rx_state_e     state_q, state_d;
    logic [2:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          s, tick;

    // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detection
    assign s = sync_q[1];
    assign tick = cnt_q == (state_q == RX_START ? HALF : FULL);
    assign byte_out = shift_q;
    assign byte_valid = state_q == RX_STOP && tick && s;
    assign frame_err = state_q == RX_STOP && tick && !s;
    assign rx_idle = state_q == RX_IDLE;

    always_comb begin
        sync_d = {sync_q[1:0], rxd};
        state_d = state_q;
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        bit_d = bit_q;
        shift_d = shift_q;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (sync_q[2] && !s) state_d = RX_START;
            end
            RX_START: if (tick) state_d = s ? RX_IDLE : RX_DATA;
            RX_DATA: if (tick) begin
                shift_d = {s, shift_q[7:1]};
                bit_d = bit_q + 1'b1;
                if (bit_q == 3'(DATA_BITS - 1)) state_d = RX_STOP;
            end
            RX_STOP: if (tick) state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
            sync_q <= '1;
            cnt_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            sync_q <= sync_d;
            cnt_q <= cnt_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
        end
    end
endmodule

// File: rtl/uart64_link.sv
// uart64_link: full-duplex UART link moving 64-bit words as 8 back-to-back 8N1 frames.
// UART64_AUTO_RESEND_EN: any change on data_in_64 also starts (or queues) a transmission.
module uart64_link
    import uart64_pkg::*;
#(
    parameter int CLK_F = 50_000_000,
    parameter int UART_BPS = 115200,
    parameter int CLK_GOAL = CLK_F / UART_BPS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] data_in_64,
    input  logic        manual_start,
    input  logic        uart_rxd,
    output logic        uart_txd,
    output logic [63:0] data_out_64,
    output logic        data_out_done
);
    localparam int CW = $clog2(CLK_GOAL + 1);
    localparam logic [CW-1:0] FULL = CW'(CLK_GOAL - 1);
    localparam int TOUT = TIMEOUT_BITS * CLK_GOAL;
    localparam int TW = $clog2(TOUT + 2);

    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d, tx_byte_q, tx_byte_d;
    logic [63:0]   tx_shift_q, tx_shift_d;
    logic          txd_q, txd_d, start_q, go, tx_tick;

`ifdef UART64_AUTO_RESEND_EN
    logic [63:0] last_q;
    logic        pend_q, pend_d, changed;
    assign changed = data_in_64 != last_q;
    assign go = (manual_start && !start_q) || changed || pend_q;
    assign pend_d = tx_state_q != TX_IDLE && (pend_q || changed);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
            pend_q <= 1'b0;
        end else begin
            last_q <= data_in_64;
            pend_q <= pend_d;
        end
    end
`else
    assign go = manual_start && !start_q;
`endif

    assign tx_tick = tx_cnt_q == FULL;

    // Shadow register shifts right one bit per data bit, so each byte arrives at [7:0] in turn
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
        tx_bit_d = tx_bit_q;
        tx_byte_d = tx_byte_q;
        tx_shift_d = tx_shift_q;
        txd_d = txd_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_byte_d = '0;
                if (go) begin
                    tx_shift_d = data_in_64;
                    tx_state_d = TX_START;
                    txd_d = 1'b0;
                end
            end
            TX_START: if (tx_tick) begin
                tx_state_d = TX_DATA;
                txd_d = tx_shift_q[0];
            end
            TX_DATA: if (tx_tick) begin
                tx_shift_d = tx_shift_q >> 1;
                tx_bit_d = tx_bit_q + 1'b1;
                txd_d = tx_bit_q == 3'(DATA_BITS - 1) ? 1'b1 : tx_shift_q[1];
                if (tx_bit_q == 3'(DATA_BITS - 1)) tx_state_d = TX_STOP;
            end
            TX_STOP: if (tx_tick) begin
                tx_byte_d = tx_byte_q + 1'b1;
                tx_state_d = tx_byte_q == 3'(BYTES_PER_WORD - 1) ? TX_IDLE : TX_START;
                txd_d = tx_byte_q == 3'(BYTES_PER_WORD - 1);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_byte_q <= '0;
            tx_shift_q <= '0;
            txd_q <= 1'b1;
            start_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q <= tx_cnt_d;
            tx_bit_q <= tx_bit_d;
            tx_byte_q <= tx_byte_d;
            tx_shift_q <= tx_shift_d;
            txd_q <= txd_d;
            start_q <= manual_start;
        end
    end

    logic [7:0]    rx_byte;
    logic          rx_valid, rx_err, rx_idle;
    logic [2:0]    rx_cnt_q, rx_cnt_d;
    logic [63:0]   rx_word_q, rx_word_d, data_out_q, data_out_d;
    logic          done_q, done_d;
    logic [TW-1:0] to_q, to_d;

    uart_byte_rx #(.CLK_GOAL(CLK_GOAL)) u_rx (
        .clk(clk),
        .rst_n(rst_n),
        .rxd(uart_rxd),
        .byte_out(rx_byte),
        .byte_valid(rx_valid),
        .frame_err(rx_err),
        .rx_idle(rx_idle)
    );

    // A stalled partial word is abandoned once the line idles past the timeout
    always_comb begin
        rx_word_d = rx_word_q;
        data_out_d = data_out_q;
        done_d = 1'b0;
        rx_cnt_d = rx_cnt_q;
        to_d = rx_idle && rx_cnt_q != '0 ? to_q + 1'b1 : '0;
        if (to_q > TW'(TOUT)) begin
            rx_cnt_d = '0;
            to_d = '0;
        end
        if (rx_err) rx_cnt_d = '0;
        if (rx_valid) begin
            rx_word_d[{rx_cnt_q, 3'b000} +: 8] = rx_byte;
            rx_cnt_d = rx_cnt_q + 1'b1;
            if (rx_cnt_q == 3'(BYTES_PER_WORD - 1)) begin
                data_out_d = rx_word_d;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_q <= '0;
            rx_word_q <= '0;
            data_out_q <= '0;
            done_q <= 1'b0;
            to_q <= '0;
        end else begin
            rx_cnt_q <= rx_cnt_d;
            rx_word_q <= rx_word_d;
            data_out_q <= data_out_d;
            done_q <= done_d;
            to_q <= to_d;
        end
    end

    assign uart_txd = txd_q;
    assign data_out_64 = data_out_q;
    assign data_out_done = done_q;
endmodule

// File: tb/tb_uart64_link.sv
// tb_uart64_link: two links on 3:2 clocks (40/60 MHz ratio) exchanging words, plus a
// bench-driven serial line for framing-error, glitch, timeout and baud-tolerance cases.
module tb_uart64_link;
    localparam int BIT = 300;
`ifdef UART64_AUTO_RESEND_EN
    localparam int BUSY_WORDS = 2;
    localparam logic [63:0] BUSY_LAST = 64'h33e22893d059fe6f;
`else
    localparam int BUSY_WORDS = 1;
    localparam logic [63:0] BUSY_LAST = 64'h9cddb2b4c4311de1;
`endif

    logic        clk_a = 0, clk_b = 0, rst_n = 1;
    logic [63:0] din_a = 0, din_b = 0, out_a, out_b;
    logic        ms_a = 0, ms_b = 0, tb_line = 1, use_tb = 0;
    logic        txd_a, txd_b, done_a, done_b, rxd_b, dprev_a = 0, dprev_b = 0;
    int          n_checks = 0, n_fail = 0, n_done_a = 0, n_done_b = 0, mcnt = 0;
    logic [63:0] qa[$], qb[$], mword = 0;
    realtime     last_end = 0, t_done_b = 0;

    always #15 clk_a = ~clk_a;
    always #10 clk_b = ~clk_b;
    assign rxd_b = use_tb ? tb_line : txd_a;

    uart64_link #(.CLK_F(40_000_000), .UART_BPS(4_000_000)) dut_a (
        .clk(clk_a), .rst_n(rst_n), .data_in_64(din_a), .manual_start(ms_a),
        .uart_rxd(txd_b), .uart_txd(txd_a), .data_out_64(out_a), .data_out_done(done_a));

    uart64_link #(.CLK_F(60_000_000), .UART_BPS(4_000_000)) dut_b (
        .clk(clk_b), .rst_n(rst_n), .data_in_64(din_b), .manual_start(ms_b),
        .uart_rxd(rxd_b), .uart_txd(txd_b), .data_out_64(out_b), .data_out_done(done_b));

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk_b) begin
        if (done_b) begin
            n_done_b++;
            t_done_b = $realtime;
            check("done_b_pulse", dprev_b, 0);
            check("done_b_expected", qb.size() != 0, 1);
            if (qb.size() != 0) check("word_b", out_b, qb.pop_front());
        end
        dprev_b = done_b;
    end

    always @(negedge clk_a) begin
        if (done_a) begin
            n_done_a++;
            check("done_a_pulse", dprev_a, 0);
            check("done_a_expected", qa.size() != 0, 1);
            if (qa.size() != 0) check("word_a", out_a, qa.pop_front());
        end
        dprev_a = done_a;
    end

    // Receiver reference: bytes fill a word LSB-first; a bad stop or a long idle restarts it
    task automatic model_byte(input logic [7:0] b, input bit ok);
        if ($realtime - last_end > 20 * BIT) mcnt = 0;
        if (!ok) mcnt = 0;
        else begin
            mword[8*mcnt +: 8] = b;
            mcnt++;
            if (mcnt == 8) begin
                qb.push_back(mword);
                mcnt = 0;
            end
        end
    endtask

    task automatic line_byte(input logic [7:0] b, input bit ok, input int per);
        model_byte(b, ok);
        tb_line = 0;
        #per;
        for (int i = 0; i < 8; i++) begin
            tb_line = b[i];
            #per;
        end
        tb_line = ok;
        #per;
        tb_line = 1;
        if (!ok) #per;
        last_end = $realtime;
    endtask

    task automatic line_word(input logic [63:0] w, input int bad, input int per);
        for (int j = 0; j < 8; j++) line_byte(w[8*j +: 8], j != bad, per);
    endtask

    task automatic send_a(input logic [63:0] w);
        @(negedge clk_a);
        din_a = w;
        ms_a = 1;
        qb.push_back(w);
        #40;
        ms_a = 0;
    endtask

    task automatic send_b(input logic [63:0] w);
        @(negedge clk_b);
        din_b = w;
        ms_b = 1;
        qa.push_back(w);
        #40;
        ms_b = 0;
    endtask

    task automatic frame_test(input logic [63:0] w);
        logic [79:0] got, exp;
        realtime ts;
        for (int j = 0; j < 8; j++) exp[10*j +: 10] = {1'b1, w[8*j +: 8], 1'b0};
        @(negedge clk_a);
        din_a = w;
        ms_a = 1;
        qb.push_back(w);
        @(negedge clk_a);
        check("start_latency", txd_a, 0);
        ts = $realtime - 15;
        #10;
        ms_a = 0;
        #125;
        for (int k = 0; k < 80; k++) begin
            got[k] = txd_a;
            #BIT;
        end
        for (int j = 0; j < 8; j++) check("frame", got[10*j +: 10], exp[10*j +: 10]);
        #600;
        check("done_latency", t_done_b > ts + 23700 && t_done_b < ts + 24000, 1);
        check("frame_missing_b", qb.size(), 0);
        check("frame_word_b", out_b, w);
    endtask

    initial begin
        logic [63:0] wa, wb;
        int n0;
        #5;
        rst_n = 0;
        #100;
        check("rst_txd_a", txd_a, 1);
        check("rst_txd_b", txd_b, 1);
        check("rst_out_a", out_a, 0);
        check("rst_out_b", out_b, 0);
        check("rst_done_a", done_a, 0);
        check("rst_done_b", done_b, 0);
        @(negedge clk_a);
        rst_n = 1;
        #300;

        frame_test(64'h9cddb2b4c4311de1);
        frame_test(64'h0000_0000_0000_00A5);

        n0 = n_done_b;
        send_a(64'h9cddb2b4c4311de1);
        #5000;
        @(negedge clk_a);
        din_a = 64'h33e22893d059fe6f;
        ms_a = 1;
`ifdef UART64_AUTO_RESEND_EN
        qb.push_back(64'h33e22893d059fe6f);
`endif
        #40;
        ms_a = 0;
        #52000;
        check("busy_done_count", n_done_b - n0, BUSY_WORDS);
        check("busy_word", out_b, BUSY_LAST);
        check("busy_missing", qb.size(), 0);

        for (int i = 0; i < 4; i++) begin
            wa = {$urandom, $urandom};
            wb = {$urandom, $urandom};
            send_a(wa);
            send_b(wb);
            #6000;
`ifndef UART64_AUTO_RESEND_EN
            din_a = {$urandom, $urandom};
            din_b = {$urandom, $urandom};
`endif
            #20000;
            check("dup_missing_b", qb.size(), 0);
            check("dup_missing_a", qa.size(), 0);
        end

        use_tb = 1;
        #1000;
        n0 = n_done_b;
        line_word(64'h9cddb2b4c4311de1, 3, BIT);
        #(2 * BIT);
        check("ferr_no_done", n_done_b - n0, 0);
        #(28 * BIT);
        tb_line = 0;
        #50;
        tb_line = 1;
        #600;
        line_word(64'h1c1624f290daa4cb, -1, BIT);
        #1000;
        check("ferr_done_count", n_done_b - n0, 1);
        check("ferr_word", out_b, 64'h1c1624f290daa4cb);
        check("ferr_missing", qb.size(), 0);

        for (int j = 0; j < 3; j++) line_byte(8'($urandom), 1, BIT);
        #(30 * BIT);
        line_word(64'h1122334455667788, -1, BIT);
        #1000;
        check("timeout_word", out_b, 64'h1122334455667788);
        check("timeout_missing", qb.size(), 0);

        line_word({$urandom, $urandom}, -1, BIT * 102 / 100);
        #(2 * BIT);
        line_word({$urandom, $urandom}, -1, BIT * 98 / 100);
        #1000;
        check("tolerance_missing", qb.size(), 0);
        use_tb = 0;
        #1000;

        send_a({$urandom, $urandom});
        #10000;
        rst_n = 0;
        din_a = 0;
        din_b = 0;
        #100;
        check("midrst_txd_a", txd_a, 1);
        check("midrst_done_b", done_b, 0);
        check("midrst_out_b", out_b, 0);
        check("midrst_out_a", out_a, 0);
        qb.delete();
        qa.delete();
        mcnt = 0;
        #200;
        @(negedge clk_a);
        rst_n = 1;
        n0 = n_done_b;
        #30000;
        check("postrst_no_done", n_done_b - n0, 0);
        check("postrst_out_b", out_b, 0);

        @(negedge clk_a);
        din_a = 64'h33e22893d059fe6f;
`ifdef UART64_AUTO_RESEND_EN
        qb.push_back(64'h33e22893d059fe6f);
        #27000;
        check("auto_word", out_b, 64'h33e22893d059fe6f);
`else
        #27000;
        check("no_auto_word", out_b, 0);
`endif
        check("auto_missing", qb.size(), 0);
        check("auto_txd_idle", txd_a, 1);

        #1000;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
